// File: rtl/mmv_ram_test_sequencer.sv
// Sequences a set of RAM test engines one at a time: the selected engine owns the shared
// memory master port while it runs, and its faults and watchdog expiries are tallied.
module mmv_ram_test_sequencer #(
    parameter int AWIDTH  = 8,
    parameter int DWIDTH  = 8,
    parameter int NTESTS  = 2,
    parameter int ECNTW   = 16,
    parameter int TOWIDTH = 20
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     start,
    input  logic [NTESTS-1:0]        test_ena,
    output logic                     ready,
    output logic                     done,
    output logic                     pass,
    output logic                     fault,
    output logic                     timeout,
    output logic [ECNTW-1:0]         err_cnt,
    output logic [2:0]               cur_test,
    output logic [NTESTS-1:0]        t_clear,
    output logic [NTESTS-1:0]        t_start,
    input  logic [NTESTS-1:0]        t_ready,
    input  logic [NTESTS-1:0]        t_fault,
    input  logic [NTESTS-1:0]        t_done,
    input  logic [NTESTS*AWIDTH-1:0] t_addr,
    input  logic [NTESTS-1:0]        t_wreq,
    input  logic [NTESTS*DWIDTH-1:0] t_wdat,
    input  logic [NTESTS-1:0]        t_rreq,
    output logic [DWIDTH-1:0]        t_rdat,
    output logic [NTESTS-1:0]        t_rval,
    output logic [NTESTS-1:0]        t_busy,
    output logic [AWIDTH-1:0]        m_addr,
    output logic                     m_wreq,
    output logic [DWIDTH-1:0]        m_wdat,
    output logic                     m_rreq,
    input  logic [DWIDTH-1:0]        m_rdat,
    input  logic                     m_rval,
    input  logic                     m_busy
);

    localparam int SELW = (NTESTS > 1) ? $clog2(NTESTS) : 1;
    // Watchdog fires on the edge where the counter would reach all ones.
    localparam logic [TOWIDTH-1:0] WD_LAST = ~TOWIDTH'(1);

    typedef enum logic [2:0] {
        IDLE, SELECT, LAUNCH, RUN, DRAIN, FINISH
    } state_t;

    state_t              state;
    logic [SELW-1:0]     sel;
    logic [NTESTS-1:0]   ena_reg;
    logic [TOWIDTH-1:0]  wd;
    logic [1:0]          dcnt;

    logic [NTESTS-1:0]   sel_oh;
    logic                active;
    logic                fault_hit;
    logic                wd_hit;
    logic [1:0]          inc;
    logic [ECNTW:0]      err_sum;
    logic [ECNTW-1:0]    err_nxt;
    logic [SELW-1:0]     nxt_sel;
    logic                nxt_found;

    assign sel_oh    = NTESTS'(1) << sel;
    assign active    = (state == LAUNCH) || (state == RUN) || (state == DRAIN);
    assign fault_hit = ((state == RUN) || (state == DRAIN)) && t_fault[sel];
    assign wd_hit    = ((state == LAUNCH) || (state == RUN)) && (wd == WD_LAST);
    assign inc       = {1'b0, fault_hit} + {1'b0, wd_hit};
    assign err_sum   = {1'b0, err_cnt} + (ECNTW+1)'(inc);
    assign err_nxt   = err_sum[ECNTW] ? '1 : err_sum[ECNTW-1:0];

    // Lowest enabled engine at or above the current index.
    always_comb begin
        nxt_sel   = '0;
        nxt_found = 1'b0;
        for (int i = NTESTS - 1; i >= 0; i--) begin
            if (ena_reg[i] && (i >= int'(sel))) begin
                nxt_sel   = SELW'(i);
                nxt_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        done    <= 1'b0;
        fault   <= 1'b0;
        t_start <= '0;
        t_clear <= '0;
        if (reset) begin
            state   <= IDLE;
            sel     <= '0;
            ena_reg <= '0;
            err_cnt <= '0;
            wd      <= '0;
            dcnt    <= '0;
            pass    <= 1'b0;
            timeout <= 1'b0;
        end else if (clear) begin
            state   <= IDLE;
            sel     <= '0;
            ena_reg <= '0;
            wd      <= '0;
            dcnt    <= '0;
            timeout <= 1'b0;
            t_clear <= '1;
        end else begin
            if (fault_hit || wd_hit)
                err_cnt <= err_nxt;
            fault <= fault_hit;
            case (state)
                IDLE: begin
                    if (start) begin
                        ena_reg <= test_ena;
                        err_cnt <= '0;
                        timeout <= 1'b0;
                        pass    <= 1'b0;
                        sel     <= '0;
                        state   <= SELECT;
                    end
                end
                SELECT: begin
                    if (nxt_found) begin
                        sel   <= nxt_sel;
                        wd    <= '0;
                        state <= LAUNCH;
                    end else begin
                        state <= FINISH;
                    end
                end
                LAUNCH: begin
                    wd <= wd + 1'b1;
                    if (wd_hit) begin
                        t_clear <= sel_oh;
                        timeout <= 1'b1;
                        dcnt    <= '0;
                        state   <= DRAIN;
                    end else if (t_ready[sel]) begin
                        t_start <= sel_oh;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    wd <= wd + 1'b1;
                    if (wd_hit) begin
                        t_clear <= sel_oh;
                        timeout <= 1'b1;
                        dcnt    <= '0;
                        state   <= DRAIN;
                    end else if (t_done[sel]) begin
                        dcnt  <= '0;
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Port stays with this engine so late read data still lands.
                    if (dcnt == 2'd3) begin
                        ena_reg[sel] <= 1'b0;
                        state        <= SELECT;
                    end else begin
                        dcnt <= dcnt + 2'd1;
                    end
                end
                FINISH: begin
                    done  <= 1'b1;
                    pass  <= (err_cnt == '0) && !timeout;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ready    = (state == IDLE);
    assign cur_test = 3'(sel);

    assign m_addr = t_addr[int'(sel)*AWIDTH +: AWIDTH];
    assign m_wdat = t_wdat[int'(sel)*DWIDTH +: DWIDTH];
    assign m_wreq = active && t_wreq[sel];
    assign m_rreq = active && t_rreq[sel];
    assign t_rdat = m_rdat;

    // Unselected engines see a permanently busy port and never see read valid.
    for (genvar g = 0; g < NTESTS; g++) begin : g_lane
        assign t_rval[g] = (sel == SELW'(g)) && m_rval;
        assign t_busy[g] = (sel == SELW'(g)) ? m_busy : 1'b1;
    end

endmodule
